// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU control sequencer and its opcode class decoder.
package cpu_seq_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_W   = 8;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned WB_W    = 2;
    localparam int unsigned RET_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [WB_W-1:0] WB_ALU = 2'd0;
    localparam logic [WB_W-1:0] WB_MEM = 2'd1;
    localparam logic [WB_W-1:0] WB_PC  = 2'd2;

    // Major opcode nibble, opcode[7:4]
    localparam logic [NIB_W-1:0] OP_RTYPE   = 4'h0;
    localparam logic [NIB_W-1:0] OP_SPECIAL = 4'h4;
    localparam logic [NIB_W-1:0] OP_SHIFT   = 4'h8;
    localparam logic [NIB_W-1:0] OP_BCOND   = 4'hC;
    localparam logic [NIB_W-1:0] OP_LUI     = 4'hF;

    // Qualifier nibble under OP_SPECIAL, opcode[3:0]
    localparam logic [NIB_W-1:0] LOAD  = 4'h0;
    localparam logic [NIB_W-1:0] STOR  = 4'h4;
    localparam logic [NIB_W-1:0] JCOND = 4'hC;
    localparam logic [NIB_W-1:0] JAL   = 4'h8;

    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_LOAD  = 3'd1,
        CLS_STOR  = 3'd2,
        CLS_BCOND = 3'd3,
        CLS_JCOND = 3'd4,
        CLS_JAL   = 3'd5
    } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode-to-instruction-class decoder; shared with the hazard logic.
module instr_class_decode
    import cpu_seq_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    output instr_class_t     o_class
);

    logic [NIB_W-1:0] w_major;
    logic [NIB_W-1:0] w_minor;

    assign w_major = i_opcode[OPC_W-1:NIB_W];
    assign w_minor = i_opcode[NIB_W-1:0];

    always_comb begin
        o_class = CLS_ALU;
        case (w_major)
            OP_RTYPE, OP_SHIFT, OP_LUI: o_class = CLS_ALU;
            OP_SPECIAL: begin
                case (w_minor)
                    LOAD:    o_class = CLS_LOAD;
                    STOR:    o_class = CLS_STOR;
                    JCOND:   o_class = CLS_JCOND;
                    JAL:     o_class = CLS_JAL;
                    default: o_class = CLS_ALU;
                endcase
            end
            OP_BCOND: o_class = CLS_BCOND;
            default:  o_class = CLS_ALU;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb control FSM for the CPU core.
// Optional SEQ_RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned PC_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ready,
    input  logic               flag_cond,
    output logic [OPC_W-1:0]   opcode,
    output logic               ir_load,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               reg_we,
    output logic [WB_W-1:0]    wb_sel,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [STATE_W-1:0] state
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [RET_W-1:0]   retired
`endif
);

    if (PC_W < 1) begin : g_pc_w_check
        $error("PC_W must be at least 1");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [OPC_W-1:0] r_opcode;
    instr_class_t     w_cls;
    logic             w_unused_instr;

    assign w_unused_instr = ^instr[OPC_W-1:0];
    assign opcode         = r_opcode;
    assign state          = r_state;

    instr_class_decode u_class (
        .i_opcode (r_opcode),
        .o_class  (w_cls)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH:  if (mem_ready) w_state_nxt = DECODE;
            DECODE: w_state_nxt = EXEC;
            EXEC:   w_state_nxt = (w_cls == CLS_LOAD || w_cls == CLS_STOR) ? MEM : FETCH;
            MEM:    if (mem_ready) w_state_nxt = (w_cls == CLS_LOAD) ? WB : FETCH;
            WB:     w_state_nxt = FETCH;
            default: w_state_nxt = FETCH;
        endcase
    end

    // Strobes are forced low while reset is held, even though state already reads FETCH
    always_comb begin
        ir_load  = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = WB_ALU;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        if (!reset) begin
            case (r_state)
                FETCH: begin
                    mem_req = 1'b1;
                    ir_load = mem_ready;
                end
                EXEC: begin
                    case (w_cls)
                        CLS_LOAD, CLS_STOR: ;
                        CLS_BCOND, CLS_JCOND: begin
                            pc_load = flag_cond;
                            pc_inc  = !flag_cond;
                        end
                        CLS_JAL: begin
                            reg_we  = 1'b1;
                            wb_sel  = WB_PC;
                            pc_load = 1'b1;
                        end
                        default: begin
                            reg_we = 1'b1;
                            pc_inc = 1'b1;
                        end
                    endcase
                end
                MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (w_cls == CLS_STOR);
                    pc_inc   = mem_ready && (w_cls == CLS_STOR);
                end
                WB: begin
                    reg_we = 1'b1;
                    wb_sel = WB_MEM;
                    pc_inc = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Opcode is held for the registered ALU translator; only a completed fetch updates it
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                r_opcode <= '0;
        else if (r_state == FETCH && mem_ready)   r_opcode <= instr[INSTR_W-1:OPC_W];
    end

`ifdef SEQ_RETIRE_CNT_EN
    logic [RET_W-1:0] r_retired;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 r_retired <= '0;
        else if (pc_inc || pc_load) r_retired <= r_retired + RET_W'(1);
    end

    assign retired = r_retired;
`endif

endmodule
